// File: rtl/pio_cmd_pkg.sv
// Shared types and field positions for the HPS<->FPGA PIO command channel.
package pio_cmd_pkg;

  localparam int WORD_W    = 32;
  localparam int PAYLOAD_W = 27;

  // Command word fields
  localparam int REQ_BIT = 31;
  localparam int OP_LSB  = 27;
  localparam int OP_W    = 4;

  // Response word fields
  localparam int ACK_BIT = 31;
  localparam int ERR_BIT = 30;
  localparam int RC_LSB  = 27;
  localparam int RC_W    = 3;

  // Status word fields; level starts at ST_LEVEL_LSB
  localparam int ST_EMPTY_BIT   = 0;
  localparam int ST_FULL_BIT    = 1;
  localparam int ST_ERR_BIT     = 2;
  localparam int ST_TIMEOUT_BIT = 3;
  localparam int ST_LEVEL_LSB   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP         = 4'd0,
    OP_WRITE       = 4'd1,
    OP_READ_STATUS = 4'd2,
    OP_CLEAR_ERR   = 4'd3,
    OP_FLUSH       = 4'd4
  } opcode_e;

  typedef enum logic [RC_W-1:0] {
    RC_OK     = 3'd0,
    RC_FULL   = 3'd1,
    RC_BAD_OP = 3'd2
  } result_e;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_EXEC,
    ST_ACK_WAIT
  } state_e;

  function automatic logic [WORD_W-1:0] make_rsp(input result_e rc,
                                                 input logic [PAYLOAD_W-1:0] payload);
    logic [WORD_W-1:0] w;
    w                        = '0;
    w[ACK_BIT]               = 1'b1;
    w[ERR_BIT]               = (rc != RC_OK);
    w[RC_LSB +: RC_W]        = rc;
    w[PAYLOAD_W-1:0]         = payload;
    return w;
  endfunction

endpackage

// File: rtl/pio_cmd_fifo.sv
// Synchronous FIFO with push/pop/flush; head word reads as zero when empty.
module pio_cmd_fifo
  #(parameter int DEPTH = 16,
    parameter int WIDTH = 27)
  (input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged before any same-cycle pop; flush overrides pop.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (flush)       rd_ptr <= wr_ptr;
      else if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; only the pointers define validity, so the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pio_cmd_responder.sv
// FPGA-side responder for the PIO command channel (4-phase REQ/ACK).
// Optional ACK_WAIT timeout enabled by defining PIO_RSP_TIMEOUT_EN.
module pio_cmd_responder
  import pio_cmd_pkg::*;
  #(parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 1000000)
  (input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_W-1:0]    pio_cmd_word,
   output logic [WORD_W-1:0]    pio_rsp_word,
   output logic [WORD_W-1:0]    pio_status_word,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [PAYLOAD_W-1:0] cmd_data);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      rsp_q, rsp_d;
  logic [WORD_W-1:0]      status_q, status_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [PAYLOAD_W-1:0]   pay_q, pay_d;
  logic                   err_q, err_d;
  logic                   tmo_flag;
  result_e                rc;
  logic [PAYLOAD_W-1:0]   rsp_pay;
  logic                   req;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_flush;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LVL_W-1:0]       fifo_level;

`ifdef PIO_RSP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  assign tmo_flag = tmo_q;
`else
  assign tmo_flag = 1'b0;
`endif

  assign req = pio_cmd_word[REQ_BIT];

  pio_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PAYLOAD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (pay_q),
    .rdata (cmd_data),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;
  assign fifo_pop  = cmd_valid && cmd_ready;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    rsp_d      = rsp_q;
    op_d       = op_q;
    pay_d      = pay_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    rc         = RC_OK;
    rsp_pay    = '0;
`ifdef PIO_RSP_TIMEOUT_EN
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
`endif

    case (state_q)
      ST_SYNC: begin
        // A REQ still high from before reset must be released before anything runs.
        if (!req) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (req) begin
          op_d    = pio_cmd_word[OP_LSB +: OP_W];
          pay_d   = pio_cmd_word[PAYLOAD_W-1:0];
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_NOP:         ;
          OP_WRITE: begin
            if (fifo_full) rc = RC_FULL;
            else           fifo_push = 1'b1;
          end
          OP_READ_STATUS: rsp_pay = status_q[PAYLOAD_W-1:0];
          OP_CLEAR_ERR: begin
            err_d = 1'b0;
`ifdef PIO_RSP_TIMEOUT_EN
            tmo_d = 1'b0;
`endif
          end
          OP_FLUSH:       fifo_flush = 1'b1;
          default:        rc = RC_BAD_OP;
        endcase
        if (rc != RC_OK) err_d = 1'b1;
        rsp_d   = make_rsp(rc, rsp_pay);
        state_d = ST_ACK_WAIT;
`ifdef PIO_RSP_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      ST_ACK_WAIT: begin
        if (!req) begin
          rsp_d   = '0;
          state_d = ST_IDLE;
        end
`ifdef PIO_RSP_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Go back through SYNC so the stuck REQ is not taken as a new command.
          rsp_d   = '0;
          tmo_d   = 1'b1;
          state_d = ST_SYNC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    status_d                            = '0;
    status_d[ST_EMPTY_BIT]              = fifo_empty;
    status_d[ST_FULL_BIT]               = fifo_full;
    status_d[ST_ERR_BIT]                = err_q;
    status_d[ST_TIMEOUT_BIT]            = tmo_flag;
    status_d[ST_LEVEL_LSB +: LVL_W]     = fifo_level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_SYNC;
      rsp_q    <= '0;
      status_q <= 32'h1;
      op_q     <= '0;
      pay_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rsp_q    <= rsp_d;
      status_q <= status_d;
      op_q     <= op_d;
      pay_q    <= pay_d;
      err_q    <= err_d;
    end
  end

`ifdef PIO_RSP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`endif

  assign pio_rsp_word    = rsp_q;
  assign pio_status_word = status_q;

endmodule
